vector_lsu: RTL and testbench
=============================

# vector_lsu

Unit-stride vector load/store sequencer downstream of the control unit. It is issued a vector load (vmem_read) or store (vmem_write) together with the decoded element width, a scalar base address (rs1) and a vector register index. It breaks the VLEN-bit transfer into 32-bit memory beats over a valid/ready bus with one request outstanding. For loads, it returns the assembled vector to the vector register file as a single write-back.

## Interface
- `VLEN`, 128: vector register width in bits; a multiple of 32, max 1024.
- `ADDR_WIDTH`, 32: memory address width.
- `VL_W`, $clog2(VLEN/8)+1: width of the vl field.
- `clk  in  1`: single clock. All state changes on the rising edge.
- `rst_n  in  1`: reset, asynchronous, active-low.
- `req_valid_i  in  1`: issue request from the decode/issue stage.
- `req_ready_o  out  1`: high only in IDLE.
- `req_is_store_i  in  1`: 1 selects store, 0 selects load.
- `req_width_i  in  2`: element width. 00=8, 01=16, 10=32, 11=64 bits.
- `req_base_addr_i  in  ADDR_WIDTH`: base byte address.
- `req_vl_i  in  VL_W`: element count.
- `req_vreg_i  in  5`: destination register (load) or source register (store).
- `req_store_data_i  in  VLEN`: store operand. Captured at acceptance.
- `mem_req_valid_o  out  1`, `mem_req_ready_i  in  1`: memory request handshake.
- `mem_we_o  out  1`: 1 for a store beat.
- `mem_addr_o  out  ADDR_WIDTH`: word address of the current beat.
- `mem_be_o  out  4`: byte enables.
- `mem_wdata_o  out  32`: store beat data.
- `mem_rvalid_i  in  1`, `mem_rdata_i  in  32`: response. Exactly one per accepted request, for both loads and stores. Arrives at least 1 cycle after acceptance.
- `vwb_valid_o  out  1`, `vwb_vreg_o  out  5`, `vwb_data_o  out  VLEN`: load write-back. 1-cycle pulse.
- `done_o  out  1`: 1-cycle completion pulse.
- `err_o  out  1`: 1-cycle misalignment pulse, coincident with done_o.
- `busy_o  out  1`: high in every state except IDLE.

## Operation
- States: IDLE, REQ, WAIT, WB, DONE.
- **IDLE.** On req_valid_i & req_ready_o, latch all request fields.
  - vlmax = VLEN/(8<<width). Effective vl = min(req_vl_i, vlmax).
  - nbytes = vl<<width. beats = ceil(nbytes/4).
  - Beat counter and address register are cleared/loaded at acceptance.
- **Misaligned base** (base[1:0]≠0) → DONE with err_o=1. No memory traffic and no write-back.
- **vl=0** → DONE with err_o=0. No memory traffic and no write-back.
- Otherwise the next state is REQ.
- **REQ.** Drive mem_req_valid_o=1 with:
  - mem_addr_o = base + 4·beat.
  - mem_we_o = store flag.
  - mem_wdata_o = store data bits [32·beat+31 : 32·beat].
  - mem_be_o = 4'hF, except on the last beat when nbytes mod 4 ≠ 0: low (nbytes mod 4) bits set.
  - Outputs are held stable until mem_req_ready_i. On handshake → WAIT.
- **WAIT.** On mem_rvalid_i:
  - Loads write mem_rdata_i into buffer beat slot; disabled bytes are written as 0.
  - If the beat was not the last: beat++ → REQ.
  - If last: loads → WB, stores → DONE.
- **WB.** vwb_valid_o=1 with the buffer and vreg, and done_o=1 → IDLE.
  - Buffer bytes ≥ nbytes are 0 (tail zeroed).
- **DONE.** done_o=1 (plus err_o if flagged) → IDLE.
- mem_rvalid_i outside WAIT is ignored.
- The load buffer is cleared at each accepted request.

## Timing
- Reset values: req_ready_o=0 during reset and 1 after; every other output 0. State IDLE, buffer 0.
- Reset mid-operation aborts immediately:
  - No done_o and no vwb_valid_o.
  - A late mem_rvalid_i after reset is ignored.
- Accept at cycle T → mem_req_valid_o at T+1. Minimum of 2 cycles per beat.
- Next beat request in the cycle after its predecessor's rvalid.
- Load write-back is in the cycle after the final rvalid. Store done_o is in the cycle after the final rvalid.
- Error/vl=0 done_o at T+1.
- req_ready_o returns at the cycle after done_o.

## Structure
- `vector_lsu_pkg`:
  - state enum.
  - width encodings VW_8/VW_16/VW_32/VW_64.
  - function computing beats and last-beat byte-enable from (vl, width).
- Single module, no sub-modules. Beat counter width is $clog2(VLEN/32)+1.

## Test plan
- Load VLEN=128, width=10, vl=4, base 0x100, zero-latency ready, rvalid next cycle:
  - 4 requests at 0x100..0x10C, be=F.
  - vwb_valid_o at T+9 with the four words concatenated, beat 0 in LSBs.
- Store width=00, vl=6, base 0x200:
  - 2 beats; second beat be=4'b0011 with data bytes [7:4].
  - done_o the cycle after the second rvalid, no vwb_valid_o.
- vl=40, width=00 (saturates to 16) and vl=0:
  - Saturated case gives 4 beats.
  - vl=0 gives done_o at T+1 with no mem_req_valid_o.
- Base 0x102 → err_o and done_o at T+1, no memory traffic, req_ready_o back at T+2.
- mem_req_ready_i held low 3 cycles with randomized rvalid delay:
  - addr/be/wdata stable while stalled.
  - Extra rvalid while in REQ ignored.
- rst_n asserted in WAIT of beat 2:
  - All outputs 0 asynchronously, no done_o.
  - Subsequent load with vl=2 returns a correct result with tail bytes zero.

Source files
------------

// File: rtl/vector_lsu_pkg.sv
// Shared types and helpers for the unit-stride vector load/store sequencer.
package vector_lsu_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_DONE
  } lsu_state_e;

  // Decoded element width encodings
  typedef enum logic [1:0] {
    VW_8  = 2'b00,
    VW_16 = 2'b01,
    VW_32 = 2'b10,
    VW_64 = 2'b11
  } vwidth_e;

  localparam int unsigned BEAT_BYTES  = 4;
  // Wide enough for the beat count of the largest supported register (1024 bits / 32)
  localparam int unsigned MAX_BEATS_W = 6;

  typedef struct packed {
    logic [MAX_BEATS_W-1:0] beats;
    logic [3:0]             last_be;
  } beat_plan_t;

  // Number of 32-bit beats and the byte enable of the final beat for vl elements
  function automatic beat_plan_t plan_beats(input int unsigned vl, input vwidth_e width);
    int unsigned nbytes;
    beat_plan_t  p;
    unique case (width)
      VW_8:    nbytes = vl;
      VW_16:   nbytes = vl << 1;
      VW_32:   nbytes = vl << 2;
      default: nbytes = vl << 3;
    endcase
    p.beats = MAX_BEATS_W'((nbytes + BEAT_BYTES - 1) / BEAT_BYTES);
    unique case (nbytes[1:0])
      2'd1:    p.last_be = 4'b0001;
      2'd2:    p.last_be = 4'b0011;
      2'd3:    p.last_be = 4'b0111;
      default: p.last_be = 4'b1111;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/vector_lsu.sv
// Unit-stride vector load/store sequencer: splits a VLEN-bit transfer into
// 32-bit memory beats (one outstanding) and returns loads as one write-back.
module vector_lsu
  import vector_lsu_pkg::*;
#(
  parameter int VLEN       = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int VL_W       = $clog2(VLEN/8) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_store_i,
  input  logic [1:0]            req_width_i,
  input  logic [ADDR_WIDTH-1:0] req_base_addr_i,
  input  logic [VL_W-1:0]       req_vl_i,
  input  logic [4:0]            req_vreg_i,
  input  logic [VLEN-1:0]       req_store_data_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  vwb_valid_o,
  output logic [4:0]            vwb_vreg_o,
  output logic [VLEN-1:0]       vwb_data_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int BEATS  = VLEN / 32;
  localparam int BEAT_W = $clog2(BEATS) + 1;

  lsu_state_e             state_q, state_d;

  logic                   is_store_q;
  logic [4:0]             vreg_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [VLEN-1:0]        sdata_q;
  logic [VLEN-1:0]        buf_q;
  logic [BEAT_W-1:0]      beat_q;
  logic [MAX_BEATS_W-1:0] beats_q;
  logic [3:0]             last_be_q;
  logic                   err_q;

  int unsigned            vlmax;
  int unsigned            vl_eff;
  beat_plan_t             plan;
  logic                   misaligned;
  logic                   vl_zero;
  logic                   accept;
  logic                   rsp_fire;
  logic                   last_beat;
  logic [3:0]             cur_be;
  logic [31:0]            be_mask;

  // Request decode: saturate vl to the register capacity and plan the beats
  always_comb begin
    vlmax      = 32'(VLEN / 8) >> req_width_i;
    vl_eff     = (32'(req_vl_i) < vlmax) ? 32'(req_vl_i) : vlmax;
    plan       = plan_beats(vl_eff, vwidth_e'(req_width_i));
    misaligned = (req_base_addr_i[1:0] != 2'b00);
    vl_zero    = (vl_eff == 0);
  end

  // Current-beat qualifiers and byte mask for partial final beats
  always_comb begin
    last_beat = ((MAX_BEATS_W'(beat_q) + MAX_BEATS_W'(1)) == beats_q);
    cur_be    = last_beat ? last_be_q : 4'hF;
    be_mask   = {{8{cur_be[3]}}, {8{cur_be[2]}}, {8{cur_be[1]}}, {8{cur_be[0]}}};
    rsp_fire  = (state_q == S_WAIT) && mem_rvalid_i;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d         = state_q;
    accept          = 1'b0;
    req_ready_o     = 1'b0;
    busy_o          = 1'b1;
    mem_req_valid_o = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_be_o        = '0;
    mem_wdata_o     = '0;
    vwb_valid_o     = 1'b0;
    vwb_vreg_o      = '0;
    vwb_data_o      = '0;
    done_o          = 1'b0;
    err_o           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_o      = 1'b0;
        // Ready is gated by reset so it reads low while reset is held
        req_ready_o = rst_n;
        if (req_valid_i && rst_n) begin
          accept  = 1'b1;
          state_d = (misaligned || vl_zero) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_we_o        = is_store_q;
        mem_addr_o      = addr_q;
        mem_be_o        = cur_be;
        mem_wdata_o     = sdata_q[32*beat_q +: 32];
        if (mem_req_ready_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid_i) begin
          if (!last_beat) begin
            state_d = S_REQ;
          end else begin
            state_d = is_store_q ? S_DONE : S_WB;
          end
        end
      end
      S_WB: begin
        vwb_valid_o = 1'b1;
        vwb_vreg_o  = vreg_q;
        vwb_data_o  = buf_q;
        done_o      = 1'b1;
        state_d     = S_IDLE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        err_o   = err_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request capture, beat/address sequencing and load buffer assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_store_q <= 1'b0;
      vreg_q     <= '0;
      addr_q     <= '0;
      sdata_q    <= '0;
      buf_q      <= '0;
      beat_q     <= '0;
      beats_q    <= '0;
      last_be_q  <= '0;
      err_q      <= 1'b0;
    end else if (accept) begin
      is_store_q <= req_is_store_i;
      vreg_q     <= req_vreg_i;
      addr_q     <= req_base_addr_i;
      sdata_q    <= req_store_data_i;
      buf_q      <= '0;
      beat_q     <= '0;
      beats_q    <= plan.beats;
      last_be_q  <= plan.last_be;
      err_q      <= misaligned;
    end else if (rsp_fire) begin
      // Disabled bytes land as zero, so the buffer tail stays clear
      if (!is_store_q) begin
        buf_q[32*beat_q +: 32] <= mem_rdata_i & be_mask;
      end
      if (!last_beat) begin
        beat_q <= beat_q + BEAT_W'(1);
        addr_q <= addr_q + ADDR_WIDTH'(4);
      end
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Scoreboard bench for vector_lsu: stimulus pushes expected memory beats and
// completion events; a monitor pops and compares as the DUT presents them.
module tb_vector_lsu;

  logic         clk;
  logic         rst_n;
  logic         req_valid_i;
  logic         req_ready_o;
  logic         req_is_store_i;
  logic [1:0]   req_width_i;
  logic [31:0]  req_base_addr_i;
  logic [6:0]   req_vl_i;
  logic [4:0]   req_vreg_i;
  logic [127:0] req_store_data_i;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [3:0]   mem_be_o;
  logic [31:0]  mem_wdata_o;
  logic         mem_rvalid_i;
  logic [31:0]  mem_rdata_i;
  logic         vwb_valid_o;
  logic [4:0]   vwb_vreg_o;
  logic [127:0] vwb_data_o;
  logic         done_o;
  logic         err_o;
  logic         busy_o;

  vector_lsu #(.VLEN(128), .ADDR_WIDTH(32), .VL_W(7)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_is_store_i   (req_is_store_i),
    .req_width_i      (req_width_i),
    .req_base_addr_i  (req_base_addr_i),
    .req_vl_i         (req_vl_i),
    .req_vreg_i       (req_vreg_i),
    .req_store_data_i (req_store_data_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_be_o         (mem_be_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_rvalid_i     (mem_rvalid_i),
    .mem_rdata_i      (mem_rdata_i),
    .vwb_valid_o      (vwb_valid_o),
    .vwb_vreg_o       (vwb_vreg_o),
    .vwb_data_o       (vwb_data_o),
    .done_o           (done_o),
    .err_o            (err_o),
    .busy_o           (busy_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cyc;
  } mreq_t;

  typedef struct {
    logic         is_wb;
    logic [4:0]   vreg;
    logic [127:0] data;
    logic         err;
    int           cyc;
  } evt_t;

  mreq_t exp_mem[$];
  evt_t  exp_evt[$];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int hs_count = 0;

  // memory responder configuration
  int stall_cfg    = 0;
  int fixed_delay  = 1;
  bit rand_delay   = 0;
  bit inject_extra = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic mreq_t mk_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                                   input logic [31:0] wd, input int c);
    mreq_t r;
    r.addr = a; r.we = we; r.be = be; r.wdata = wd; r.cyc = c;
    return r;
  endfunction

  function automatic evt_t mk_evt(input logic is_wb, input logic [4:0] vr, input logic [127:0] d,
                                  input logic err, input int c);
    evt_t e;
    e.is_wb = is_wb; e.vreg = vr; e.data = d; e.err = err; e.cyc = c;
    return e;
  endfunction

  // Memory model: ready/stall control and one delayed response per accepted beat
  initial begin
    int          rsp_cnt;
    int          stall_left;
    logic        req_seen;
    logic [31:0] rsp_addr;
    rsp_cnt = 0; stall_left = 0; req_seen = 1'b0; rsp_addr = '0;
    mem_req_ready_i = 1'b0;
    mem_rvalid_i    = 1'b0;
    mem_rdata_i     = '0;
    forever begin
      @(negedge clk);
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid_i = 1'b1;
          mem_rdata_i  = 32'hA500_0000 | rsp_addr;
        end
      end
      if (mem_req_valid_o) begin
        if (!req_seen) begin
          req_seen   = 1'b1;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          mem_req_ready_i = 1'b0;
          if (inject_extra && stall_left == 2 && rsp_cnt == 0 && !mem_rvalid_i) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
          end
          stall_left--;
        end else begin
          mem_req_ready_i = 1'b1;
          req_seen        = 1'b0;
          rsp_cnt         = rand_delay ? int'($urandom_range(1, 4)) : fixed_delay;
          rsp_addr        = mem_addr_o;
        end
      end else begin
        mem_req_ready_i = 1'b0;
      end
    end
  end

  // Monitor: compares beats at handshake, stability while stalled, and completions
  initial begin
    mreq_t       e;
    evt_t        ev;
    logic        stall_cap;
    logic [31:0] c_addr, c_wdata;
    logic [3:0]  c_be;
    logic        c_we;
    stall_cap = 1'b0;
    c_addr = '0; c_wdata = '0; c_be = '0; c_we = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        stall_cap = 1'b0;
        continue;
      end
      if (mem_req_valid_o) begin
        if (stall_cap) begin
          chk("stall_addr", mem_addr_o, c_addr);
          chk("stall_be", mem_be_o, c_be);
          chk("stall_wdata", mem_wdata_o, c_wdata);
          chk("stall_we", mem_we_o, c_we);
        end
        if (!mem_req_ready_i) begin
          stall_cap = 1'b1;
          c_addr = mem_addr_o; c_be = mem_be_o; c_wdata = mem_wdata_o; c_we = mem_we_o;
        end else begin
          stall_cap = 1'b0;
          hs_count++;
          if (exp_mem.size() == 0) begin
            fail_now("unexpected_mem_req");
          end else begin
            e = exp_mem.pop_front();
            chk("mem_addr", mem_addr_o, e.addr);
            chk("mem_we", mem_we_o, e.we);
            chk("mem_be", mem_be_o, e.be);
            chk("mem_wdata", mem_wdata_o, e.wdata);
            if (e.cyc >= 0) chk("mem_cycle", cyc, e.cyc);
          end
        end
      end
      if (vwb_valid_o || done_o) begin
        if (exp_evt.size() == 0) begin
          fail_now("unexpected_done_or_wb");
        end else begin
          ev = exp_evt.pop_front();
          chk("done", done_o, 1'b1);
          chk("wb_valid", vwb_valid_o, ev.is_wb);
          chk("err", err_o, ev.err);
          if (ev.is_wb) begin
            chk("wb_vreg", vwb_vreg_o, ev.vreg);
            chk("wb_data", vwb_data_o, ev.data);
          end
          if (ev.cyc >= 0) chk("done_cycle", cyc, ev.cyc);
        end
      end else if (err_o) begin
        fail_now("err_without_done");
      end
    end
  end

  task automatic wait_ready(output int t);
    int n = 0;
    while (!req_ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready_o) fail_now("ready_timeout");
    t = cyc;
  endtask

  task automatic send(input logic st, input logic [1:0] w, input logic [31:0] base,
                      input logic [6:0] vl, input logic [4:0] vr, input logic [127:0] sd);
    req_valid_i      = 1'b1;
    req_is_store_i   = st;
    req_width_i      = w;
    req_base_addr_i  = base;
    req_vl_i         = vl;
    req_vreg_i       = vr;
    req_store_data_i = sd;
    @(posedge clk); #1;
    req_valid_i      = 1'b0;
    req_is_store_i   = 1'b0;
    req_width_i      = '0;
    req_base_addr_i  = '0;
    req_vl_i         = '0;
    req_vreg_i       = '0;
    req_store_data_i = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_mem.size() != 0 || exp_evt.size() != 0 || !req_ready_o) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) fail_now(name);
  endtask

  // Watchdog so the run always ends with a summary
  initial begin
    #200000;
    fail_now("global_timeout");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int t;
    int n;
    int hs0;
    logic [127:0] sd;
    rst_n = 1'b0;
    req_valid_i = 1'b0; req_is_store_i = 1'b0; req_width_i = '0; req_base_addr_i = '0;
    req_vl_i = '0; req_vreg_i = '0; req_store_data_i = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_low", req_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_mem_valid", mem_req_valid_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", req_ready_o, 1'b1);
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_wb_data", vwb_data_o, 128'h0);

    // 32-bit load, vl=4: four full beats, write-back at T+9
    wait_ready(t);
    for (int i = 0; i < 4; i++)
      exp_mem.push_back(mk_req(32'h100 + 32'(4*i), 1'b0, 4'hF, 32'h0, t + 1 + 2*i));
    exp_evt.push_back(mk_evt(1'b1, 5'd3, 128'hA500010C_A5000108_A5000104_A5000100, 1'b0, t + 9));
    send(1'b0, 2'b10, 32'h100, 7'd4, 5'd3, '0);
    drain("load32_drain");

    // byte store, vl=6: two beats, second partial, done after final response
    sd = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    wait_ready(t);
    exp_mem.push_back(mk_req(32'h200, 1'b1, 4'hF,    32'h03020100, t + 1));
    exp_mem.push_back(mk_req(32'h204, 1'b1, 4'b0011, 32'h07060504, t + 3));
    exp_evt.push_back(mk_evt(1'b0, 5'd0, '0, 1'b0, t + 5));
    send(1'b1, 2'b00, 32'h200, 7'd6, 5'd7, sd);
    drain("store8_drain");

    // byte load with vl=40 saturates to 16 elements
    wait_ready(t);
    for (int i = 0; i < 4; i++)
      exp_mem.push_back(mk_req(32'h500 + 32'(4*i), 1'b0, 4'hF, 32'h0, t + 1 + 2*i));
    exp_evt.push_back(mk_evt(1'b1, 5'd9, 128'hA500050C_A5000508_A5000504_A5000500, 1'b0, t + 9));
    send(1'b0, 2'b00, 32'h500, 7'd40, 5'd9, '0);
    drain("sat_drain");

    // vl=0: immediate completion, no memory traffic
    wait_ready(t);
    exp_evt.push_back(mk_evt(1'b0, 5'd0, '0, 1'b0, t + 1));
    send(1'b0, 2'b10, 32'h600, 7'd0, 5'd1, '0);
    drain("vl0_drain");

    // misaligned base: error completion at T+1, ready back at T+2
    wait_ready(t);
    exp_evt.push_back(mk_evt(1'b0, 5'd0, '0, 1'b1, t + 1));
    send(1'b0, 2'b10, 32'h102, 7'd4, 5'd4, '0);
    chk("err_ready_low", req_ready_o, 1'b0);
    chk("err_busy", busy_o, 1'b1);
    @(posedge clk); #1;
    chk("err_ready_back", req_ready_o, 1'b1);
    drain("err_drain");

    // stalled ready, random response delay, stray rvalid while requesting
    stall_cfg = 3; rand_delay = 1'b1; inject_extra = 1'b1;
    wait_ready(t);
    exp_mem.push_back(mk_req(32'h700, 1'b0, 4'hF,    32'h0, -1));
    exp_mem.push_back(mk_req(32'h704, 1'b0, 4'hF,    32'h0, -1));
    exp_mem.push_back(mk_req(32'h708, 1'b0, 4'b0011, 32'h0, -1));
    exp_evt.push_back(mk_evt(1'b1, 5'd12, 128'h00000000_00000708_A5000704_A5000700, 1'b0, -1));
    send(1'b0, 2'b01, 32'h700, 7'd5, 5'd12, '0);
    drain("stall_drain");
    stall_cfg = 0; rand_delay = 1'b0; inject_extra = 1'b0;

    // reset while waiting on beat 2; the late response must be ignored
    fixed_delay = 3;
    wait_ready(t);
    for (int i = 0; i < 4; i++)
      exp_mem.push_back(mk_req(32'h300 + 32'(4*i), 1'b0, 4'hF, 32'h0, -1));
    exp_evt.push_back(mk_evt(1'b1, 5'd2, '0, 1'b0, -1));
    hs0 = hs_count;
    send(1'b0, 2'b10, 32'h300, 7'd4, 5'd2, '0);
    n = 0;
    while (hs_count != hs0 + 3 && n < 200) begin
      @(negedge clk); #2;
      n++;
    end
    if (hs_count != hs0 + 3) fail_now("beat2_timeout");
    @(posedge clk); #3;
    chk("pre_rst_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ready", req_ready_o, 1'b0);
    chk("arst_mem_valid", mem_req_valid_o, 1'b0);
    chk("arst_addr", mem_addr_o, 32'h0);
    chk("arst_done", done_o, 1'b0);
    chk("arst_wb", vwb_valid_o, 1'b0);
    chk("arst_wb_data", vwb_data_o, 128'h0);
    exp_mem.delete();
    exp_evt.delete();
    @(posedge clk); #2;
    rst_n = 1'b1;
    fixed_delay = 1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_abort_ready", req_ready_o, 1'b1);
    chk("post_abort_busy", busy_o, 1'b0);

    // fresh byte load, vl=2: single partial beat, tail zero
    wait_ready(t);
    exp_mem.push_back(mk_req(32'h400, 1'b0, 4'b0011, 32'h0, t + 1));
    exp_evt.push_back(mk_evt(1'b1, 5'd5, 128'h00000000_00000000_00000000_00000400, 1'b0, t + 3));
    send(1'b0, 2'b00, 32'h400, 7'd2, 5'd5, '0);
    drain("tail_drain");

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
